stream_flush_gate: RTL and testbench
====================================

Name: stream_flush_gate

Overview:
- Upstream companion to the flushable spill register.
- Passes a valid/ready/data stream through combinationally while idle.
- On a flush request, blocks the stream and drives a multi-cycle flush pulse downstream.
- Guarantees that flush and valid are never high together on its outputs, so a downstream flushable stage cannot lose an accepted beat. It also counts beats delivered since the last flush.

Parameters:
- T, 1, data width in bits (>=1)
- FlushCycles, 1, cycles flush_o is held high per flush (>=1)
- GuardCycles, 1, idle cycles after flush_o drops before the stream is re-opened (>=0)
- CntWidth, 16, width of beat counter (>=1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- flush_req_i  in  1  flush request, sampled each cycle
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_i  in  T  upstream data
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- data_o  out  T  downstream data
- flush_o  out  1  downstream flush
- busy_o  out  1  high while state != PASS
- beats_o  out  CntWidth  handshakes (valid_o && ready_i) since last flush, saturating
- flush_cnt_o  out  CntWidth  completed flushes (see Optional Feature)

Behaviour:
- Reset: rst_i is synchronous and active-high, sampled on the rising edge of clk_i. It forces state=PASS and clears both counters to 0. Outputs after reset: flush_o=0, busy_o=0, beats_o=0, flush_cnt_o=0. valid_o, ready_o and data_o follow the PASS equations.
- FSM states are PASS, FLUSH and GUARD. Internal counter phase_q has width clog2(max(FlushCycles,GuardCycles,1)+1).
- PASS:
  - valid_o=valid_i, ready_o=ready_i, data_o=data_i. No added latency.
  - flush_o=0, busy_o=0.
  - If flush_req_i=1: next state=FLUSH, phase_q<=0. The handshake in the request cycle still completes normally.
- FLUSH:
  - valid_o=0, ready_o=0, flush_o=1, busy_o=1. data_o=data_i (don't-care).
  - phase_q increments each cycle.
  - When phase_q==FlushCycles-1: if GuardCycles>0, next state=GUARD with phase_q<=0; otherwise next state=PASS.
  - flush_o is therefore high for exactly FlushCycles consecutive cycles.
- GUARD:
  - valid_o=0, ready_o=0, flush_o=0, busy_o=1.
  - After GuardCycles cycles, next state=PASS.
- flush_req_i is ignored while busy_o=1. Requests are not queued; the requester watches busy_o.
- Upstream is back-pressured (ready_o=0) during FLUSH and GUARD. Upstream data is held, not dropped, and is presented again on return to PASS.
- beats_o:
  - Increments by 1 on each cycle with valid_o && ready_i.
  - Saturates at 2^CntWidth-1; no wrap-around.
  - Cleared to 0 in the first FLUSH cycle.
  - The request-cycle handshake is counted before the clear takes effect: that handshake is in the final value, then the counter clears.
- Invariant: flush_o && valid_o is never 1.
- Reset mid-FLUSH or mid-GUARD: next cycle is PASS, flush_o=0, counters 0.
- Simultaneous rst_i and flush_req_i: reset wins.

Optional Feature:
- Macro: STREAM_FLUSH_GATE_STATS_EN.
- Defined: flush_cnt_o increments by 1 on each FLUSH->GUARD or FLUSH->PASS transition, saturating at 2^CntWidth-1, cleared only by rst_i.
- Undefined: flush_cnt_o is tied to '0 and no counter flops are instantiated.
- The port exists in both builds.

Test Plan:
- Stream pass-through: T=8, ready_i=1, 5 beats 0x11..0x15 -> data_o equals data_i in the same cycle, beats_o=5, flush_o never high.
- Basic flush: FlushCycles=2, GuardCycles=1, flush_req_i pulse at cycle 10 -> flush_o=1 in cycles 11-12, GUARD in cycle 13, ready_o/valid_o=0 in cycles 11-13, PASS in cycle 14, busy_o=1 in cycles 11-13, beats_o=0 from cycle 12.
- Back-pressure hold: valid_i=1 with data 0xA5 held through the flush -> no handshake during busy, then 0xA5 is accepted in the first PASS cycle with ready_i=1; exclusion of flush_o and valid_o checked every cycle.
- Ignored request: flush_req_i held high for 6 cycles with FlushCycles=1, GuardCycles=0 -> flush_o alternates 1,0,1,0,... Each flush is 1 cycle; requests while busy are dropped; flush_cnt_o=3 with macro defined, 0 without.
- Saturation: CntWidth=2, 6 handshakes -> beats_o sequence 1,2,3,3,3,3.
- Reset mid-flush: FlushCycles=4, rst_i=1 in the second FLUSH cycle -> next cycle state=PASS, flush_o=0, busy_o=0, beats_o=0, flush_cnt_o=0.

Source files
------------

// File: rtl/stream_flush_gate.sv
// Stream gate that blocks a valid/ready stream and drives a multi-cycle flush pulse downstream.
// Optional flush statistics counter enabled by defining STREAM_FLUSH_GATE_STATS_EN.
module stream_flush_gate #(
    parameter int unsigned T           = 1,
    parameter int unsigned FlushCycles = 1,
    parameter int unsigned GuardCycles = 1,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_req_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [T-1:0]        data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [T-1:0]        data_o,
    output logic                flush_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] beats_o,
    output logic [CntWidth-1:0] flush_cnt_o
);

    localparam int unsigned PhMax = (FlushCycles > GuardCycles) ? FlushCycles : GuardCycles;
    localparam int unsigned PhW   = $clog2(PhMax + 1);
    localparam logic [PhW-1:0] FlushLast = PhW'(FlushCycles - 1);
    localparam logic [PhW-1:0] GuardLast = PhW'((GuardCycles > 0) ? GuardCycles - 1 : 0);

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        FLUSH = 2'd1,
        GUARD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PhW-1:0]       phase_q, phase_d;
    logic [CntWidth-1:0]  beats_q;

    // Valid/ready: a beat transfers on a cycle where valid and ready are both high;
    // the gate only forwards both directions in PASS, so no beat moves while busy.

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PASS;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            PASS: begin
                if (flush_req_i) begin
                    state_d = FLUSH;
                    phase_d = '0;
                end
            end
            FLUSH: begin
                if (phase_q == FlushLast) begin
                    phase_d = '0;
                    if (GuardCycles > 0) state_d = GUARD;
                    else                 state_d = PASS;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            GUARD: begin
                if (phase_q == GuardLast) begin
                    state_d = PASS;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            default: begin
                state_d = PASS;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        flush_o = 1'b0;
        busy_o  = 1'b1;
        case (state_q)
            PASS: begin
                valid_o = valid_i;
                ready_o = ready_i;
                busy_o  = 1'b0;
            end
            FLUSH:   flush_o = 1'b1;
            default: ;
        endcase
    end

    assign data_o = data_i;

    // Any FLUSH cycle clears; the request-cycle beat was already counted in PASS.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == FLUSH) begin
            beats_q <= '0;
        end else if (valid_o && ready_i && beats_q != '1) begin
            beats_q <= beats_q + CntWidth'(1);
        end
    end

    assign beats_o = beats_q;

`ifdef STREAM_FLUSH_GATE_STATS_EN
    logic                flush_done;
    logic [CntWidth-1:0] flush_cnt_q;

    assign flush_done = (state_q == FLUSH) && (phase_q == FlushLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_cnt_q <= '0;
        end else if (flush_done && flush_cnt_q != '1) begin
            flush_cnt_q <= flush_cnt_q + CntWidth'(1);
        end
    end

    assign flush_cnt_o = flush_cnt_q;
`else
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_flush_gate.sv
// Bench for stream_flush_gate: two configurations driven by shared stimulus and
// compared every cycle against a countdown-based reference model.
module tb_stream_flush_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, flush_req_i, valid_i, ready_i;
    logic [7:0] data_i;

    // Instance a: FlushCycles=3, GuardCycles=2, CntWidth=3
    logic       a_ready_o, a_valid_o, a_flush_o, a_busy_o;
    logic [7:0] a_data_o;
    logic [2:0] a_beats_o, a_flush_cnt_o;
    // Instance b: FlushCycles=1, GuardCycles=0, CntWidth=2
    logic       b_ready_o, b_valid_o, b_flush_o, b_busy_o;
    logic [7:0] b_data_o;
    logic [1:0] b_beats_o, b_flush_cnt_o;

    stream_flush_gate #(.T(8), .FlushCycles(3), .GuardCycles(2), .CntWidth(3)) u_a (
        .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i),
        .valid_i(valid_i), .ready_o(a_ready_o), .data_i(data_i),
        .valid_o(a_valid_o), .ready_i(ready_i), .data_o(a_data_o),
        .flush_o(a_flush_o), .busy_o(a_busy_o),
        .beats_o(a_beats_o), .flush_cnt_o(a_flush_cnt_o)
    );

    stream_flush_gate #(.T(8), .FlushCycles(1), .GuardCycles(0), .CntWidth(2)) u_b (
        .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i),
        .valid_i(valid_i), .ready_o(b_ready_o), .data_i(data_i),
        .valid_o(b_valid_o), .ready_i(ready_i), .data_o(b_data_o),
        .flush_o(b_flush_o), .busy_o(b_busy_o),
        .beats_o(b_beats_o), .flush_cnt_o(b_flush_cnt_o)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit model_ok = 1'b0;

    // Reference model: rem counts remaining busy cycles (flush cycles then guard cycles).
    int rem[2];
    int beats[2];
    int fcnt[2];

    function automatic int fl(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int gd(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 7 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input string nm,
                              input logic v, input logic r, input logic [7:0] d,
                              input logic f, input logic b,
                              input logic [31:0] bt, input logic [31:0] fc);
        bit busy;
        int exp_fc;
        busy = (rem[i] != 0);
`ifdef STREAM_FLUSH_GATE_STATS_EN
        exp_fc = fcnt[i];
`else
        exp_fc = 0;
`endif
        check_eq({nm, ".valid_o"}, 32'(v), 32'(busy ? 1'b0 : valid_i));
        check_eq({nm, ".ready_o"}, 32'(r), 32'(busy ? 1'b0 : ready_i));
        check_eq({nm, ".data_o"},  32'(d), 32'(data_i));
        check_eq({nm, ".flush_o"}, 32'(f), 32'(rem[i] > gd(i)));
        check_eq({nm, ".busy_o"},  32'(b), 32'(busy));
        check_eq({nm, ".beats_o"}, bt, 32'(beats[i]));
        check_eq({nm, ".flush_cnt_o"}, fc, 32'(exp_fc));
        check_eq({nm, ".excl"}, 32'(f & v), 32'd0);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int f;
            int g;
            f = fl(i);
            g = gd(i);
            if (rst_i) begin
                rem[i] = 0; beats[i] = 0; fcnt[i] = 0;
            end else if (rem[i] != 0) begin
                if (rem[i] == f + g) beats[i] = 0;
                if (rem[i] == g + 1 && fcnt[i] < cmax(i)) fcnt[i]++;
                rem[i]--;
            end else begin
                if (valid_i && ready_i && beats[i] < cmax(i)) beats[i]++;
                if (flush_req_i) rem[i] = f + g;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic fr, input logic v,
                         input logic r, input logic [7:0] d);
        @(negedge clk);
        rst_i = rst; flush_req_i = fr; valid_i = v; ready_i = r; data_i = d;
        #1;
        if (model_ok) begin
            check_inst(0, "a", a_valid_o, a_ready_o, a_data_o, a_flush_o, a_busy_o,
                       32'(a_beats_o), 32'(a_flush_cnt_o));
            check_inst(1, "b", b_valid_o, b_ready_o, b_data_o, b_flush_o, b_busy_o,
                       32'(b_beats_o), 32'(b_flush_cnt_o));
        end
        model_step();
        if (rst) model_ok = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; flush_req_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = 8'h00;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // pass-through beats 0x11..0x15; instance b saturates at 3
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h11 + k));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // flush pulse with a handshake in the request cycle, then 0xA5 held through busy
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
        repeat (7) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
        // request held high: requests while busy are dropped
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // saturation run
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'(k));
        // reset in the second flush cycle
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        // simultaneous reset and request
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h78);
        // randomized traffic
        repeat (800) begin
            cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  8'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
